rtu_rob: RTL
============

RTU_ROB -- requirements
Module: rtu_rob

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, number of entries; fixed by 4-bit iid.
REQ-002 SHALL have clk  input  1  sole clock, rising edge.
REQ-003 SHALL have rst_clk  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have idu_rtu_rob_alloc_vld  input  1  dispatch requests one entry.
REQ-005 SHALL have idu_rtu_rob_alloc_pc  input  64  instruction pc.
REQ-006 SHALL have idu_rtu_rob_alloc_pdst_vld / idu_rtu_rob_alloc_pdst / idu_rtu_rob_alloc_old_pdst  input  1/6/6  new and previous physical destination.
REQ-007 SHALL have rtu_idu_rob_alloc_iid  output  4  iid granted to current allocation.
REQ-008 SHALL have rtu_idu_rob_full  output  1  no free entry.
REQ-009 SHALL have exu_rtu_rob_alu_complete / exu_rtu_rob_alu_iid  input  1/4  ALU completion.
REQ-010 SHALL have exu_rtu_rob_bju_complete / exu_rtu_rob_bju_iid / exu_rtu_rob_bju_flush / exu_rtu_rob_bju_target  input  1/4/1/64  branch completion, mispredict flag, redirect pc.
REQ-011 SHALL have rtu_idu_retire_vld / rtu_idu_retire_pdst_vld / rtu_idu_retire_pdst / rtu_idu_retire_old_pdst  output  1/1/6/6  in-order retirement, old_pdst released to free list.
REQ-012 SHALL have rtu_global_flush  output  1  pipeline-wide flush.
REQ-013 SHALL have rtu_ifu_flush_pc  output  64  redirect pc, valid with rtu_global_flush.
REQ-014 SHALL have rtu_rob_empty  output  1  no valid entry.

Function
REQ-015 SHALL keep head/tail pointers 5 bits (index + wrap bit); full = indices equal, wrap differs; empty = pointers equal.
REQ-016 SHALL grant allocation when alloc_vld & ~full & ~rtu_global_flush; rtu_idu_rob_alloc_iid = tail[3:0] combinationally; entry written and tail incremented at that edge, valid=1, done=0, flush=0.
REQ-017 SHALL ignore alloc_vld when full, using pre-edge full even if retire occurs same cycle.
REQ-018 SHALL set done on edge where ALU or BJU completion names a valid entry; both naming same iid same cycle OR together; completion to invalid entry ignored.
REQ-019 SHALL on BJU completion also store flush flag and target in that entry.
REQ-020 SHALL drive retire outputs combinationally when head entry valid & done; head advances and entry invalidated at that edge; max one retire per cycle; earliest retire is cycle after completion.
REQ-021 SHALL assert rtu_global_flush for exactly the retire cycle of a flush-marked entry, with rtu_ifu_flush_pc = its target; that entry still retires (retire_vld=1).
REQ-022 SHALL on a flush edge clear all valid/done/flush bits and reset head and tail to 0, discarding same-cycle allocation and completions.
REQ-023 SHALL hold retire, flush outputs at 0 when head not done or ROB empty; rtu_ifu_flush_pc 0 when not flushing.
REQ-024 SHALL handle pointer wrap from index 15 to 0 with wrap-bit toggle, no lost entry.

Reset
REQ-025 SHALL on rst_clk low clear pointers and all entry state asynchronously: full=0, empty=1, alloc_iid=0, all retire outputs 0, rtu_global_flush=0, rtu_ifu_flush_pc=0.
REQ-026 SHALL abandon in-flight entries on reset mid-operation; first allocation after release gets iid 0.

Structure
REQ-027 SHALL take ROB_DEPTH, iid width and preg width from the shared rtu/exu definitions file.
REQ-028 SHALL be single module; entry storage as per-field register arrays, no sub-module.

Verification
REQ-029 Alloc 3 (iid 0,1,2), complete ALU iid 2 then 0 then 1 -> retires in order 0,1,2 on cycles after iid1 done; empty=1 after.
REQ-030 Alloc 16 without completion -> full=1, 17th alloc ignored, tail unchanged; complete+retire iid 0 -> next alloc gets iid 0.
REQ-031 Alloc iid 0,1,2; BJU completes iid 1 flush=1 target 64'h8000_0100; complete 0,2 -> cycle of iid1 retire: global_flush=1, flush_pc=64'h8000_0100; next cycle empty=1, next alloc iid 0, iid 2 never retires.
REQ-032 ALU and BJU complete same iid same cycle -> single done, retires once.
REQ-033 Drop rst_clk with 5 valid entries -> outputs zero immediately; after release alloc_iid=0, empty=1.
REQ-034 Run 40 alloc/complete/retire rounds -> iid wraps 15->0 correctly, retire order matches allocation.

Source files
------------

// File: rtl/rtu_rob_pkg.sv
// Shared RTU/EXU sizing for the reorder buffer: entry count, iid, pointer and preg widths.
package rtu_rob_pkg;

  localparam int unsigned RTU_ROB_DEPTH = 16;
  localparam int unsigned IID_W         = 4;
  localparam int unsigned PTR_W         = IID_W + 1;
  localparam int unsigned PREG_W        = 6;
  localparam int unsigned PC_W          = 64;

  typedef logic [IID_W-1:0]  iid_t;
  typedef logic [PTR_W-1:0]  rob_ptr_t;
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PC_W-1:0]   pc_t;

  function automatic rob_ptr_t ptr_inc(input rob_ptr_t p);
    return p + rob_ptr_t'(1);
  endfunction

endpackage

// File: rtl/rtu_rob.sv
// In-order retirement buffer: allocates iids at dispatch, marks completions from ALU/BJU,
// retires one entry per cycle and raises a global flush when a mispredicted branch retires.
module rtu_rob
  import rtu_rob_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = RTU_ROB_DEPTH
) (
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              idu_rtu_rob_alloc_vld,
  input  logic [63:0]       idu_rtu_rob_alloc_pc,
  input  logic              idu_rtu_rob_alloc_pdst_vld,
  input  logic [5:0]        idu_rtu_rob_alloc_pdst,
  input  logic [5:0]        idu_rtu_rob_alloc_old_pdst,
  output logic [3:0]        rtu_idu_rob_alloc_iid,
  output logic              rtu_idu_rob_full,
  input  logic              exu_rtu_rob_alu_complete,
  input  logic [3:0]        exu_rtu_rob_alu_iid,
  input  logic              exu_rtu_rob_bju_complete,
  input  logic [3:0]        exu_rtu_rob_bju_iid,
  input  logic              exu_rtu_rob_bju_flush,
  input  logic [63:0]       exu_rtu_rob_bju_target,
  output logic              rtu_idu_retire_vld,
  output logic              rtu_idu_retire_pdst_vld,
  output logic [5:0]        rtu_idu_retire_pdst,
  output logic [5:0]        rtu_idu_retire_old_pdst,
  output logic              rtu_global_flush,
  output logic [63:0]       rtu_ifu_flush_pc,
  output logic              rtu_rob_empty
);

  rob_ptr_t              r_head;
  rob_ptr_t              r_tail;

  logic [ROB_DEPTH-1:0]  r_vld;
  logic [ROB_DEPTH-1:0]  r_done;
  logic [ROB_DEPTH-1:0]  r_flush;
  logic [ROB_DEPTH-1:0]  r_pdst_vld;
  preg_t                 r_pdst     [ROB_DEPTH];
  preg_t                 r_old_pdst [ROB_DEPTH];
  pc_t                   r_target   [ROB_DEPTH];

  iid_t                  w_head_idx;
  iid_t                  w_tail_idx;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_alloc;
  logic                  w_retire;
  logic                  w_flush;
  logic                  w_unused_pc;

  // The pc travels with dispatch for debug visibility only; nothing here consumes it.
  assign w_unused_pc = ^idu_rtu_rob_alloc_pc;

  assign w_head_idx = r_head[IID_W-1:0];
  assign w_tail_idx = r_tail[IID_W-1:0];
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IID_W] != r_tail[IID_W]);
  assign w_empty    = (r_head == r_tail);
  assign w_retire   = r_vld[w_head_idx] & r_done[w_head_idx];
  assign w_flush    = w_retire & r_flush[w_head_idx];
  assign w_alloc    = idu_rtu_rob_alloc_vld & ~w_full & ~w_flush;

  always_comb begin
    rtu_idu_rob_alloc_iid   = w_tail_idx;
    rtu_idu_rob_full        = w_full;
    rtu_rob_empty           = w_empty;
    rtu_idu_retire_vld      = w_retire;
    rtu_idu_retire_pdst_vld = 1'b0;
    rtu_idu_retire_pdst     = '0;
    rtu_idu_retire_old_pdst = '0;
    rtu_global_flush        = w_flush;
    rtu_ifu_flush_pc        = '0;
    if (w_retire) begin
      rtu_idu_retire_pdst_vld = r_pdst_vld[w_head_idx];
      rtu_idu_retire_pdst     = r_pdst[w_head_idx];
      rtu_idu_retire_old_pdst = r_old_pdst[w_head_idx];
    end
    if (w_flush) begin
      rtu_ifu_flush_pc = r_target[w_head_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (w_flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_alloc) begin
        r_tail <= ptr_inc(r_tail);
      end
      if (w_retire) begin
        r_head <= ptr_inc(r_head);
      end
    end
  end

  // Completion is qualified by the pre-edge valid bit, so a completion naming the slot
  // being allocated this cycle cannot mark the new instruction done.
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      r_vld      <= '0;
      r_done     <= '0;
      r_flush    <= '0;
      r_pdst_vld <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        r_pdst[i]     <= '0;
        r_old_pdst[i] <= '0;
        r_target[i]   <= '0;
      end
    end else if (w_flush) begin
      r_vld   <= '0;
      r_done  <= '0;
      r_flush <= '0;
    end else begin
      if (w_alloc) begin
        r_vld[w_tail_idx]      <= 1'b1;
        r_done[w_tail_idx]     <= 1'b0;
        r_flush[w_tail_idx]    <= 1'b0;
        r_pdst_vld[w_tail_idx] <= idu_rtu_rob_alloc_pdst_vld;
        r_pdst[w_tail_idx]     <= idu_rtu_rob_alloc_pdst;
        r_old_pdst[w_tail_idx] <= idu_rtu_rob_alloc_old_pdst;
      end
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        if (r_vld[i]) begin
          if (exu_rtu_rob_alu_complete && (exu_rtu_rob_alu_iid == i[IID_W-1:0])) begin
            r_done[i] <= 1'b1;
          end
          if (exu_rtu_rob_bju_complete && (exu_rtu_rob_bju_iid == i[IID_W-1:0])) begin
            r_done[i]   <= 1'b1;
            r_flush[i]  <= exu_rtu_rob_bju_flush;
            r_target[i] <= exu_rtu_rob_bju_target;
          end
        end
      end
      if (w_retire) begin
        r_vld[w_head_idx] <= 1'b0;
      end
    end
  end

endmodule
